// File: rtl/axi_slave_ram.sv
// AXI4 slave word RAM with independent read and write channel FSMs.
// Supports INCR/FIXED bursts, byte strobes and a fixed number of read wait states.
module axi_slave_ram #(
    parameter int unsigned C_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_OFFSET_WIDTH   = 28,
    parameter int unsigned C_MEM_WORDS_LOG2 = 11,
    parameter int unsigned C_RD_WAIT        = 2
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [C_OFFSET_WIDTH-1:0]     AWADDR,
    input  logic [7:0]                    AWLEN,
    input  logic [1:0]                    AWBURST,
    input  logic                          AWVALID,
    output logic                          AWREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0]   WDATA,
    input  logic [C_AXI_DATA_WIDTH/8-1:0] WSTRB,
    input  logic                          WLAST,
    input  logic                          WVALID,
    output logic                          WREADY,
    output logic [1:0]                    BRESP,
    output logic                          BVALID,
    input  logic                          BREADY,
    input  logic [C_OFFSET_WIDTH-1:0]     ARADDR,
    input  logic [7:0]                    ARLEN,
    input  logic [1:0]                    ARBURST,
    input  logic                          ARVALID,
    output logic                          ARREADY,
    output logic [C_AXI_DATA_WIDTH-1:0]   RDATA,
    output logic [1:0]                    RRESP,
    output logic                          RLAST,
    output logic                          RVALID,
    input  logic                          RREADY
);

    localparam int unsigned IDX_W = C_MEM_WORDS_LOG2;
    localparam int unsigned DEPTH = 1 << C_MEM_WORDS_LOG2;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [3:0] WAIT_INIT = (C_RD_WAIT == 0) ? 4'd0 : 4'(C_RD_WAIT - 1);

    typedef enum logic [1:0] {WIdle, WData, WResp} w_state_t;
    typedef enum logic [1:0] {RIdle, RWait, RData} r_state_t;

    logic [C_AXI_DATA_WIDTH-1:0] ram_array [0:DEPTH-1];

    w_state_t         w_state;
    logic [IDX_W-1:0] w_idx;
    logic [7:0]       w_cnt;
    logic             w_fixed;
    logic             w_bad;
    logic             w_err;
    logic             ram_we;
    logic             w_last_bad;

    r_state_t         r_state;
    logic [IDX_W-1:0] r_idx;
    logic [7:0]       r_cnt;
    logic [3:0]       r_wait;
    logic             r_fixed;
    logic             r_bad;

    logic             aw_bad;
    logic             ar_bad;
    logic [IDX_W-1:0] ar_idx;
    logic             unused_addr_lsbs;

    // Bursts that touch bits above the RAM index, or use WRAP/reserved types, are error bursts.
    assign aw_bad = (|AWADDR[C_OFFSET_WIDTH-1:IDX_W+2]) || AWBURST[1];
    assign ar_bad = (|ARADDR[C_OFFSET_WIDTH-1:IDX_W+2]) || ARBURST[1];
    assign ar_idx = ARADDR[IDX_W+1:2];
    assign unused_addr_lsbs = ^{AWADDR[1:0], ARADDR[1:0]};

    assign ram_we     = (w_state == WData) && WVALID && !w_bad;
    assign w_last_bad = (WLAST != (w_cnt == 8'd0));

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx, input logic fixed);
        return fixed ? idx : idx + 1'b1;
    endfunction

    always_ff @(posedge CLK) begin
        if (ram_we) begin
            for (int b = 0; b < C_AXI_DATA_WIDTH / 8; b++) begin
                if (WSTRB[b]) ram_array[w_idx][8*b +: 8] <= WDATA[8*b +: 8];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            w_state <= WIdle;
            AWREADY <= 1'b0;
            WREADY  <= 1'b0;
            BVALID  <= 1'b0;
            BRESP   <= OKAY;
            w_idx   <= '0;
            w_cnt   <= '0;
            w_fixed <= 1'b0;
            w_bad   <= 1'b0;
            w_err   <= 1'b0;
        end else begin
            case (w_state)
                WIdle: begin
                    if (AWREADY && AWVALID) begin
                        AWREADY <= 1'b0;
                        WREADY  <= 1'b1;
                        w_idx   <= AWADDR[IDX_W+1:2];
                        w_cnt   <= AWLEN;
                        w_fixed <= (AWBURST == 2'b00);
                        w_bad   <= aw_bad;
                        w_err   <= aw_bad;
                        w_state <= WData;
                    end else begin
                        AWREADY <= 1'b1;
                    end
                end
                WData: begin
                    if (WVALID) begin
                        w_idx <= next_idx(w_idx, w_fixed);
                        w_cnt <= w_cnt - 8'd1;
                        if (w_last_bad) w_err <= 1'b1;
                        // AWLEN, not WLAST, decides where the burst ends.
                        if (w_cnt == 8'd0) begin
                            WREADY  <= 1'b0;
                            BVALID  <= 1'b1;
                            BRESP   <= (w_err || w_last_bad) ? SLVERR : OKAY;
                            w_state <= WResp;
                        end
                    end
                end
                WResp: begin
                    if (BREADY) begin
                        BVALID  <= 1'b0;
                        BRESP   <= OKAY;
                        AWREADY <= 1'b1;
                        w_state <= WIdle;
                    end
                end
                default: w_state <= WIdle;
            endcase
        end
    end

    // RDATA is loaded from the RAM on the edge a beat becomes current, so back-to-back
    // beats need no bubble and a same-edge write is not seen by the read.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= RIdle;
            ARREADY <= 1'b0;
            RVALID  <= 1'b0;
            RLAST   <= 1'b0;
            RRESP   <= OKAY;
            RDATA   <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_wait  <= '0;
            r_fixed <= 1'b0;
            r_bad   <= 1'b0;
        end else begin
            case (r_state)
                RIdle: begin
                    if (ARREADY && ARVALID) begin
                        ARREADY <= 1'b0;
                        r_cnt   <= ARLEN;
                        r_fixed <= (ARBURST == 2'b00);
                        r_bad   <= ar_bad;
                        if (C_RD_WAIT == 0) begin
                            RVALID  <= 1'b1;
                            RLAST   <= (ARLEN == 8'd0);
                            RRESP   <= ar_bad ? SLVERR : OKAY;
                            RDATA   <= ar_bad ? '0 : ram_array[ar_idx];
                            r_idx   <= next_idx(ar_idx, ARBURST == 2'b00);
                            r_state <= RData;
                        end else begin
                            r_idx   <= ar_idx;
                            r_wait  <= WAIT_INIT;
                            r_state <= RWait;
                        end
                    end else begin
                        ARREADY <= 1'b1;
                    end
                end
                RWait: begin
                    if (r_wait == 4'd0) begin
                        RVALID  <= 1'b1;
                        RLAST   <= (r_cnt == 8'd0);
                        RRESP   <= r_bad ? SLVERR : OKAY;
                        RDATA   <= r_bad ? '0 : ram_array[r_idx];
                        r_idx   <= next_idx(r_idx, r_fixed);
                        r_state <= RData;
                    end else begin
                        r_wait <= r_wait - 4'd1;
                    end
                end
                RData: begin
                    if (RREADY) begin
                        if (RLAST) begin
                            RVALID  <= 1'b0;
                            RLAST   <= 1'b0;
                            RRESP   <= OKAY;
                            RDATA   <= '0;
                            ARREADY <= 1'b1;
                            r_state <= RIdle;
                        end else begin
                            RDATA <= r_bad ? '0 : ram_array[r_idx];
                            r_idx <= next_idx(r_idx, r_fixed);
                            r_cnt <= r_cnt - 8'd1;
                            RLAST <= (r_cnt == 8'd1);
                        end
                    end
                end
                default: r_state <= RIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_slave_ram.sv
// Directed bench for axi_slave_ram: a word-level memory model predicts every R and B beat,
// and a negedge monitor compares them; literal checks pin the key vectors.
module tb_axi_slave_ram;

    localparam int unsigned RD_WAIT = 2;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] AWADDR = '0;
    logic [7:0]  AWLEN = '0;
    logic [1:0]  AWBURST = '0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [31:0] WDATA = '0;
    logic [3:0]  WSTRB = '0;
    logic        WLAST = 1'b0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY = 1'b1;
    logic [31:0] ARADDR = '0;
    logic [7:0]  ARLEN = '0;
    logic [1:0]  ARBURST = '0;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY = 1'b0;

    axi_slave_ram #(
        .C_AXI_DATA_WIDTH(32),
        .C_OFFSET_WIDTH  (32),
        .C_MEM_WORDS_LOG2(11),
        .C_RD_WAIT       (RD_WAIT)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .AWADDR (AWADDR),
        .AWLEN  (AWLEN),
        .AWBURST(AWBURST),
        .AWVALID(AWVALID),
        .AWREADY(AWREADY),
        .WDATA  (WDATA),
        .WSTRB  (WSTRB),
        .WLAST  (WLAST),
        .WVALID (WVALID),
        .WREADY (WREADY),
        .BRESP  (BRESP),
        .BVALID (BVALID),
        .BREADY (BREADY),
        .ARADDR (ARADDR),
        .ARLEN  (ARLEN),
        .ARBURST(ARBURST),
        .ARVALID(ARVALID),
        .ARREADY(ARREADY),
        .RDATA  (RDATA),
        .RRESP  (RRESP),
        .RLAST  (RLAST),
        .RVALID (RVALID),
        .RREADY (RREADY)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  r;
        logic        l;
    } rbeat_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mdl [0:2047];
    rbeat_t      exp_r [$];
    logic [1:0]  exp_b [$];
    logic [31:0] got_d [$];
    logic [1:0]  got_rr [$];
    logic [1:0]  got_b [$];
    logic [31:0] wbuf [0:15];
    bit          pat [0:15];
    int          npat = 0;
    int          first_cyc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every beat the DUT presents must match the front of the model queue.
    always @(negedge CLK) begin
        if (RST) begin
            chk("reset_outputs_zero",
                {32'd0, AWREADY, WREADY, BVALID, BRESP, ARREADY, RVALID, RLAST, RRESP, |RDATA}, 64'd0);
        end else begin
            if (RVALID) begin
                if (exp_r.size() == 0) begin
                    chk("r_unexpected_beat", {63'd0, RVALID}, 64'd0);
                end else begin
                    chk("r_beat", {29'd0, RDATA, RRESP, RLAST}, {29'd0, exp_r[0]});
                    if (RREADY) begin
                        got_d.push_back(RDATA);
                        got_rr.push_back(RRESP);
                        void'(exp_r.pop_front());
                    end
                end
            end
            if (BVALID) begin
                if (exp_b.size() == 0) begin
                    chk("b_unexpected", {63'd0, BVALID}, 64'd0);
                end else begin
                    chk("b_resp", {62'd0, BRESP}, {62'd0, exp_b[0]});
                    if (BREADY) begin
                        got_b.push_back(BRESP);
                        void'(exp_b.pop_front());
                    end
                end
            end
        end
    end

    function automatic bit is_bad(input logic [31:0] addr, input logic [1:0] burst);
        return (addr[31:13] != 0) || (burst > 2'd1);
    endfunction

    task automatic do_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                            input logic [3:0] strb, input bit bad_last);
        logic [10:0] idx;
        bit          bad;
        int          n;
        idx = addr[12:2];
        bad = is_bad(addr, burst);
        for (int i = 0; i <= len; i++) begin
            if (!bad)
                for (int b = 0; b < 4; b++)
                    if (strb[b]) mdl[idx][8*b +: 8] = wbuf[i][8*b +: 8];
            if (burst == 2'd1) idx = idx + 11'd1;
        end
        exp_b.push_back((bad || bad_last) ? 2'b10 : 2'b00);

        AWADDR = addr; AWLEN = len[7:0]; AWBURST = burst; AWVALID = 1'b1;
        n = 0;
        do begin @(negedge CLK); n++; end while (!AWREADY && n < 50);
        chk("aw_handshake", {63'd0, AWREADY}, 64'd1);
        @(posedge CLK); #1 AWVALID = 1'b0;
        for (int i = 0; i <= len; i++) begin
            WDATA = wbuf[i]; WSTRB = strb; WLAST = (i == len) ^ bad_last; WVALID = 1'b1;
            n = 0;
            do begin @(negedge CLK); n++; end while (!WREADY && n < 50);
            chk("w_handshake", {63'd0, WREADY}, 64'd1);
            @(posedge CLK); #1;
        end
        WVALID = 1'b0; WLAST = 1'b0;
        n = 0;
        do begin @(negedge CLK); n++; end while (!BVALID && n < 50);
        chk("b_arrives", {63'd0, BVALID}, 64'd1);
        @(posedge CLK); #1;
    endtask

    task automatic issue_ar(input logic [31:0] addr, input int len, input logic [1:0] burst);
        logic [10:0] idx;
        bit          bad;
        rbeat_t      e;
        int          n;
        idx = addr[12:2];
        bad = is_bad(addr, burst);
        for (int i = 0; i <= len; i++) begin
            e.d = bad ? 32'd0 : mdl[idx];
            e.r = bad ? 2'b10 : 2'b00;
            e.l = (i == len);
            exp_r.push_back(e);
            if (burst == 2'd1) idx = idx + 11'd1;
        end
        ARADDR = addr; ARLEN = len[7:0]; ARBURST = burst; ARVALID = 1'b1;
        n = 0;
        do begin @(negedge CLK); n++; end while (!ARREADY && n < 50);
        chk("ar_handshake", {63'd0, ARREADY}, 64'd1);
        @(posedge CLK); #1 ARVALID = 1'b0;
    endtask

    // RREADY follows pat[] on cycles where RVALID is up, then stays high.
    task automatic do_read(input logic [31:0] addr, input int len, input logic [1:0] burst);
        int got = 0;
        int k = 0;
        int cyc = 0;
        got_d.delete(); got_rr.delete();
        first_cyc = -1;
        issue_ar(addr, len, burst);
        while (got <= len && cyc < 200) begin
            if (RVALID) begin
                if (first_cyc < 0) first_cyc = cyc;
                RREADY = (k < npat) ? pat[k] : 1'b1;
                k++;
            end else begin
                RREADY = 1'b0;
            end
            @(negedge CLK);
            if (RVALID && RREADY) got++;
            @(posedge CLK); #1;
            cyc++;
        end
        RREADY = 1'b0;
        npat = 0;
        chk("r_burst_complete", 64'(got), 64'(len + 1));
    endtask

    initial begin
        int hs;
        int n;
        // Reset and idle
        repeat (3) @(negedge CLK);
        #1 RST = 1'b0;
        chk("awready_before_edge", {63'd0, AWREADY}, 64'd0);
        @(posedge CLK); #1;
        chk("ready_after_reset", {60'd0, AWREADY, ARREADY, BVALID, RVALID}, {60'd0, 4'b1100});

        for (int i = 0; i < 4; i++) begin
            dut.ram_array[i] = 32'(i + 1);
            mdl[i] = 32'(i + 1);
        end
        dut.ram_array[8] = 32'h1122_3344;
        mdl[8] = 32'h1122_3344;

        // Single write then read with latency check
        wbuf[0] = 32'h3E80_0093;
        got_b.delete();
        do_write(32'h10, 0, 2'd1, 4'hF, 1'b0);
        chk("single_wr_bresp", {62'd0, got_b[0]}, 64'd0);
        chk("single_wr_ram", {32'd0, dut.ram_array[4]}, 64'h3E80_0093);
        do_read(32'h10, 0, 2'd1);
        chk("single_rd_latency", 64'(first_cyc), 64'(RD_WAIT));
        chk("single_rd_data", {32'd0, got_d[0]}, 64'h3E80_0093);

        // INCR read with RREADY back-pressure
        pat[0] = 1; pat[1] = 0; pat[2] = 1; pat[3] = 1; pat[4] = 0; pat[5] = 1; npat = 6;
        do_read(32'h0, 3, 2'd1);
        chk("incr_rd_beats", {got_d[0], got_d[1]}, {32'd1, 32'd2});
        chk("incr_rd_beats_hi", {got_d[2], got_d[3]}, {32'd3, 32'd4});

        // Byte strobes
        wbuf[0] = 32'hAABB_CCDD;
        do_write(32'h20, 0, 2'd1, 4'b0101, 1'b0);
        do_read(32'h20, 0, 2'd1);
        chk("strobe_rd", {32'd0, got_d[0]}, 64'h11BB_33DD);

        // INCR burst wrapping past the top word
        wbuf[0] = 32'hCAFE_0001; wbuf[1] = 32'hCAFE_0002;
        got_b.delete();
        do_write(32'h1FFC, 1, 2'd1, 4'hF, 1'b0);
        chk("top_wr_bresp", {62'd0, got_b[0]}, 64'd0);
        chk("top_wr_ram", {dut.ram_array[2047], dut.ram_array[0]}, {32'hCAFE_0001, 32'hCAFE_0002});
        do_read(32'h1FFC, 1, 2'd1);

        // Out-of-range read and write
        do_read(32'h4000_0000, 0, 2'd1);
        chk("oor_rd", {30'd0, got_d[0], got_rr[0]}, {30'd0, 32'd0, 2'b10});
        wbuf[0] = 32'hDEAD_BEEF;
        got_b.delete();
        do_write(32'h4000_0010, 0, 2'd1, 4'hF, 1'b0);
        chk("oor_wr_bresp", {62'd0, got_b[0]}, 64'h2);
        chk("oor_wr_no_write", {32'd0, dut.ram_array[4]}, 64'h3E80_0093);

        // FIXED burst, WRAP burst, WLAST mismatch
        wbuf[0] = 32'd5; wbuf[1] = 32'd6; wbuf[2] = 32'd7;
        do_write(32'h30, 2, 2'd0, 4'hF, 1'b0);
        chk("fixed_wr_ram", {32'd0, dut.ram_array[12]}, 64'd7);
        do_read(32'h30, 1, 2'd0);
        chk("fixed_rd", {got_d[0], got_d[1]}, {32'd7, 32'd7});
        do_read(32'h30, 1, 2'd2);
        wbuf[0] = 32'h1; wbuf[1] = 32'h2;
        got_b.delete();
        do_write(32'h40, 1, 2'd1, 4'hF, 1'b1);
        chk("wlast_mismatch_bresp", {62'd0, got_b[0]}, 64'h2);

        // Reset in the middle of an 8-beat read
        issue_ar(32'h0, 7, 2'd1);
        RREADY = 1'b1;
        hs = 0; n = 0;
        while (hs < 2 && n < 50) begin
            @(negedge CLK);
            if (RVALID && RREADY) hs++;
            n++;
        end
        chk("midrst_two_beats", 64'(hs), 64'd2);
        @(posedge CLK);
        #2 RST = 1'b1;
        exp_r.delete();
        RREADY = 1'b0;
        #1;
        chk("midrst_rvalid_drop", {62'd0, RVALID, ARREADY}, 64'd0);
        repeat (2) @(negedge CLK);
        #1 RST = 1'b0;
        @(posedge CLK); #1;
        chk("midrst_ready_back", {62'd0, ARREADY, AWREADY}, 64'h3);
        do_read(32'h10, 0, 2'd1);
        chk("post_rst_rd", {32'd0, got_d[0]}, 64'h3E80_0093);

        repeat (3) @(posedge CLK);
        chk("no_pending_beats", 64'(exp_r.size() + exp_b.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
